// File: rtl/data_packer.sv
// Purpose: packs NUM_NARROW narrow source-BRAM elements, first element in the MS slice, into wide destination-BRAM words.
// Latency: one read per cycle from cycle 1; word w written in cycle min((w+1)*RATIO, NUM_NARROW)+2; o_done in cycle NUM_NARROW+3.
// Backpressure: none; both BRAM ports are always ready and i_start is ignored outside IDLE.
`ifndef CLOG2
`define CLOG2(x) (((x) > 1) ? $clog2(x) : 1)
`endif

module data_packer #(
   parameter int NARROW_WIDTH           = 8,
   parameter int WIDE_WIDTH             = 32,
   parameter int SOURCE_BRAM_DEPTH      = 16,
   parameter int DESTINATION_BRAM_DEPTH = 4,
   parameter int NUM_NARROW             = 16
) (
   input  logic                                       i_clk,
   input  logic                                       i_rst,
   input  logic                                       i_start,
   output logic                                       o_done,
   input  logic [NARROW_WIDTH-1:0]                    i_narrow_in,
   output logic [`CLOG2(SOURCE_BRAM_DEPTH)-1:0]       o_narrow_in_addr,
   output logic                                       o_narrow_in_rd,
   output logic [WIDE_WIDTH-1:0]                      o_wide_out,
   output logic [`CLOG2(DESTINATION_BRAM_DEPTH)-1:0]  o_wide_out_addr,
   output logic                                       o_wide_out_en
);

   localparam int RATIO  = WIDE_WIDTH / NARROW_WIDTH;
   localparam int SRC_AW = `CLOG2(SOURCE_BRAM_DEPTH);
   localparam int DST_AW = `CLOG2(DESTINATION_BRAM_DEPTH);
   localparam int SLC_W  = `CLOG2(RATIO);
   localparam int CNT_W  = `CLOG2(NUM_NARROW + 1);

   localparam logic [SRC_AW-1:0] LAST_ADDR  = SRC_AW'(NUM_NARROW - 1);
   localparam logic [CNT_W-1:0]  LAST_CAP   = CNT_W'(NUM_NARROW - 1);
   localparam logic [SLC_W-1:0]  LAST_SLICE = SLC_W'(RATIO - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_READ  = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   logic [1:0]            state;
   logic                  flush_cnt;   // FLUSH lasts two cycles: last capture, then last write
   logic                  rd_vld_d;    // a read was issued last cycle, so i_narrow_in is valid now
   logic [CNT_W-1:0]      cap_cnt;     // elements captured so far in this run
   logic [SLC_W-1:0]      slice_cnt;   // slice the next captured element lands in
   logic [DST_AW-1:0]     word_cnt;    // destination address of the word being assembled
   logic [WIDE_WIDTH-1:0] acc;
   logic [WIDE_WIDTH-1:0] acc_nxt;
   logic                  cap_last;
   logic                  word_full;

   // Merge the element arriving this cycle into its slice; slice 0 is the most significant.
   always_comb begin
      acc_nxt = acc;
      for (int s = 0; s < RATIO; s++) begin
         if (slice_cnt == SLC_W'(s)) begin
            acc_nxt[WIDE_WIDTH-1-s*NARROW_WIDTH -: NARROW_WIDTH] = i_narrow_in;
         end
      end
   end

   // A word is emitted when its last slice fills or the run runs out of elements (zero-padded tail).
   assign cap_last  = (cap_cnt == LAST_CAP);
   assign word_full = (slice_cnt == LAST_SLICE) || cap_last;

   // Sequencer: back-to-back reads, two drain cycles for the read latency and write register, then a done pulse.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state            <= ST_IDLE;
         flush_cnt        <= 1'b0;
         o_narrow_in_rd   <= 1'b0;
         o_narrow_in_addr <= '0;
         o_done           <= 1'b0;
      end else begin
         o_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (i_start) begin
                  state            <= ST_READ;
                  o_narrow_in_rd   <= 1'b1;
                  o_narrow_in_addr <= '0;
               end
            end
            ST_READ: begin
               if (o_narrow_in_addr == LAST_ADDR) begin
                  state            <= ST_FLUSH;
                  o_narrow_in_rd   <= 1'b0;
                  o_narrow_in_addr <= '0;
                  flush_cnt        <= 1'b0;
               end else begin
                  o_narrow_in_addr <= o_narrow_in_addr + 1'b1;
               end
            end
            ST_FLUSH: begin
               if (flush_cnt) begin
                  state  <= ST_DONE;
                  o_done <= 1'b1;
               end else begin
                  flush_cnt <= 1'b1;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Capture returning elements and register each completed word onto the write port for one cycle.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rd_vld_d        <= 1'b0;
         cap_cnt         <= '0;
         slice_cnt       <= '0;
         word_cnt        <= '0;
         acc             <= '0;
         o_wide_out      <= '0;
         o_wide_out_addr <= '0;
         o_wide_out_en   <= 1'b0;
      end else begin
         rd_vld_d        <= o_narrow_in_rd;
         o_wide_out_en   <= 1'b0;
         o_wide_out      <= '0;
         o_wide_out_addr <= '0;
         if (state == ST_IDLE) begin
            cap_cnt   <= '0;
            slice_cnt <= '0;
            word_cnt  <= '0;
            acc       <= '0;
         end else if (rd_vld_d) begin
            cap_cnt <= cap_cnt + 1'b1;
            if (word_full) begin
               o_wide_out_en   <= 1'b1;
               o_wide_out      <= acc_nxt;
               o_wide_out_addr <= word_cnt;
               word_cnt        <= word_cnt + 1'b1;
               slice_cnt       <= '0;
               acc             <= '0;
            end else begin
               slice_cnt <= slice_cnt + 1'b1;
               acc       <= acc_nxt;
            end
         end
      end
   end

endmodule

// File: tb/tb_data_packer.sv
// Purpose: randomized self-checking bench for data_packer with NUM_NARROW = 16, 14 and 1 instances.
// Latency: expected write/done/read cycles come from a behavioural model of the packing rules.
// Backpressure: none; source BRAMs are modelled with a one-cycle registered read.
module tb_data_packer;

   localparam int NW  = 8;
   localparam int WW  = 32;
   localparam int SD  = 16;
   localparam int DD  = 4;
   localparam int R   = WW / NW;
   localparam int SAW = $clog2(SD);
   localparam int DAW = $clog2(DD);

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [2:0] start = '0;

   wire [2:0]          done;
   wire [2:0]          rd;
   wire [2:0]          wen;
   wire [2:0][SAW-1:0] raddr;
   wire [2:0][DAW-1:0] waddr;
   wire [2:0][WW-1:0]  wdat;

   logic [NW-1:0] src_mem [3][SD];

   int checks = 0;
   int passes = 0;

   // Observed events of the last run: writes as cycle*16+addr, reads as cycle*256+addr.
   int            w_ev[$];
   logic [WW-1:0] w_dat[$];
   int            d_ev[$];
   int            r_ev[$];
   int            idle_bad;
   // Expected events from the model.
   int            ew_ev[$];
   logic [WW-1:0] ew_dat[$];
   int            ed_ev[$];
   int            er_ev[$];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : inst
      localparam int NN = (g == 0) ? 16 : ((g == 1) ? 14 : 1);
      logic [NW-1:0] nin;
      // Registered source BRAM with one-cycle read latency.
      always @(posedge clk) if (rd[g]) nin <= src_mem[g][raddr[g]];
      data_packer #(
         .NARROW_WIDTH(NW), .WIDE_WIDTH(WW), .SOURCE_BRAM_DEPTH(SD),
         .DESTINATION_BRAM_DEPTH(DD), .NUM_NARROW(NN)
      ) dut (
         .i_clk(clk), .i_rst(rst), .i_start(start[g]), .o_done(done[g]),
         .i_narrow_in(nin), .o_narrow_in_addr(raddr[g]), .o_narrow_in_rd(rd[g]),
         .o_wide_out(wdat[g]), .o_wide_out_addr(waddr[g]), .o_wide_out_en(wen[g])
      );
   end

   function automatic int nn_of(input int g);
      return (g == 0) ? 16 : ((g == 1) ? 14 : 1);
   endfunction

   task automatic clear_model();
      ew_ev.delete(); ew_dat.delete(); ed_ev.delete(); er_ev.delete();
   endtask

   // Model: element k goes to word k/R, MS slice first, zero padded; run started in cycle t0.
   task automatic model_run(input int g, input int nn, input int t0);
      int nw;
      int last;
      logic [WW-1:0] word;
      nw = (nn + R - 1) / R;
      for (int w = 0; w < nw; w++) begin
         word = '0;
         for (int s = 0; s < R; s++)
            word = (word << NW) | ((w * R + s < nn) ? WW'(src_mem[g][w * R + s]) : WW'(0));
         last = ((w + 1) * R < nn) ? (w + 1) * R : nn;
         ew_ev.push_back((t0 + last + 2) * 16 + w);
         ew_dat.push_back(word);
      end
      for (int n = 1; n <= nn; n++) er_ev.push_back((t0 + n) * 256 + n - 1);
      ed_ev.push_back(t0 + nn + 3);
   endtask

   // Drives one run (start in cycle 0, optional extra start pulses and a reset cycle) and records events.
   task automatic run_capture(input int g, input int ncyc, input int p1, input int p2, input int p3, input int rc);
      w_ev.delete(); w_dat.delete(); d_ev.delete(); r_ev.delete(); idle_bad = 0;
      for (int c = 0; c < ncyc; c++) begin
         @(posedge clk); #1;
         start[g] = (c == 0) || (c == p1) || (c == p2) || (c == p3);
         rst      = (c == rc);
         @(negedge clk);
         if (wen[g]) begin
            w_ev.push_back(c * 16 + int'(waddr[g]));
            w_dat.push_back(wdat[g]);
         end else if (waddr[g] != '0 || wdat[g] != '0) idle_bad++;
         if (rd[g]) r_ev.push_back(c * 256 + int'(raddr[g]));
         else if (raddr[g] != '0) idle_bad++;
         if (done[g]) d_ev.push_back(c);
      end
      @(posedge clk); #1;
      start = '0;
      rst   = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 3'b111;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
         checks++;
         if ({done[g], rd[g], wen[g], raddr[g], waddr[g], wdat[g]} !== '0)
            $display("FAIL reset_outputs inst%0d got done=%b rd=%b en=%b raddr=%0d waddr=%0d data=%h want all 0",
                     g, done[g], rd[g], wen[g], raddr[g], waddr[g], wdat[g]);
         else passes++;
      end
      @(posedge clk); #1; rst = 1'b0; start = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (rd !== 3'b000 || wen !== 3'b000 || done !== 3'b000)
         $display("FAIL reset_start_ignored got rd=%b en=%b done=%b want 000", rd, wen, done);
      else passes++;
   endtask

   task automatic test_basic();
      for (int k = 0; k < SD; k++) src_mem[0][k] = NW'(k);
      clear_model(); model_run(0, 16, 0);
      run_capture(0, 24, -1, -1, -1, -1);
      checks++;
      if (w_ev.size() != ew_ev.size()) $display("FAIL basic_nwrites got %0d want %0d", w_ev.size(), ew_ev.size());
      else passes++;
      for (int i = 0; i < w_ev.size() && i < ew_ev.size(); i++) begin
         checks++;
         if (w_ev[i] !== ew_ev[i] || w_dat[i] !== ew_dat[i])
            $display("FAIL basic_write%0d got cyc %0d addr %0d data %h want cyc %0d addr %0d data %h",
                     i, w_ev[i] / 16, w_ev[i] % 16, w_dat[i], ew_ev[i] / 16, ew_ev[i] % 16, ew_dat[i]);
         else passes++;
      end
      checks++;
      if (w_dat.size() > 0 && w_dat[0] !== 32'h00010203) $display("FAIL basic_word0 got %h want 00010203", w_dat[0]);
      else passes++;
      checks++;
      if (d_ev.size() != 1 || d_ev[0] != 19) $display("FAIL basic_done got %0d pulses first %0d want 1 pulse at 19",
                                                      d_ev.size(), (d_ev.size() > 0) ? d_ev[0] : -1);
      else passes++;
      checks++;
      if (r_ev.size() != er_ev.size()) $display("FAIL basic_nreads got %0d want %0d", r_ev.size(), er_ev.size());
      else passes++;
      for (int i = 0; i < r_ev.size() && i < er_ev.size(); i++) begin
         checks++;
         if (r_ev[i] !== er_ev[i])
            $display("FAIL basic_read%0d got cyc %0d addr %0d want cyc %0d addr %0d",
                     i, r_ev[i] / 256, r_ev[i] % 256, er_ev[i] / 256, er_ev[i] % 256);
         else passes++;
      end
      checks++;
      if (idle_bad != 0) $display("FAIL basic_idle_zero got %0d nonzero idle outputs want 0", idle_bad);
      else passes++;
   endtask

   task automatic test_partial();
      for (int k = 0; k < SD; k++) src_mem[1][k] = NW'(k);
      clear_model(); model_run(1, 14, 0);
      run_capture(1, 22, -1, -1, -1, -1);
      checks++;
      if (w_ev.size() != 4) $display("FAIL partial_nwrites got %0d want 4", w_ev.size());
      else passes++;
      for (int i = 0; i < w_ev.size() && i < ew_ev.size(); i++) begin
         checks++;
         if (w_ev[i] !== ew_ev[i] || w_dat[i] !== ew_dat[i])
            $display("FAIL partial_write%0d got cyc %0d addr %0d data %h want cyc %0d addr %0d data %h",
                     i, w_ev[i] / 16, w_ev[i] % 16, w_dat[i], ew_ev[i] / 16, ew_ev[i] % 16, ew_dat[i]);
         else passes++;
      end
      checks++;
      if (w_dat.size() == 4 && (w_dat[3] !== 32'h0C0D0000 || w_ev[3] / 16 != 16))
         $display("FAIL partial_last got %h at cyc %0d want 0c0d0000 at 16", w_dat[3], w_ev[3] / 16);
      else passes++;
      checks++;
      if (d_ev.size() != 1 || d_ev[0] != ed_ev[0]) $display("FAIL partial_done got %0d pulses first %0d want 1 at %0d",
                                                         d_ev.size(), (d_ev.size() > 0) ? d_ev[0] : -1, ed_ev[0]);
      else passes++;
      checks++;
      if (r_ev.size() != 14 || idle_bad != 0) $display("FAIL partial_reads got %0d reads %0d idle errs want 14 and 0", r_ev.size(), idle_bad);
      else passes++;
   endtask

   task automatic test_minimal();
      src_mem[2][0] = 8'hA5;
      for (int k = 1; k < SD; k++) src_mem[2][k] = NW'($urandom);
      run_capture(2, 10, -1, -1, -1, -1);
      checks++;
      if (w_ev.size() != 1 || w_ev[0] != 3 * 16 || w_dat[0] !== 32'hA5000000)
         $display("FAIL minimal_write got %0d writes first cyc %0d data %h want 1 write cyc 3 data a5000000",
                  w_ev.size(), (w_ev.size() > 0) ? w_ev[0] / 16 : -1, (w_dat.size() > 0) ? w_dat[0] : 32'h0);
      else passes++;
      checks++;
      if (d_ev.size() != 1 || d_ev[0] != 4) $display("FAIL minimal_done got %0d pulses first %0d want 1 at 4",
                                                     d_ev.size(), (d_ev.size() > 0) ? d_ev[0] : -1);
      else passes++;
      checks++;
      if (r_ev.size() != 1 || r_ev[0] != 256) $display("FAIL minimal_reads got %0d reads want 1 at cycle 1 addr 0", r_ev.size());
      else passes++;
   endtask

   task automatic test_start_busy();
      for (int k = 0; k < SD; k++) src_mem[0][k] = NW'($urandom);
      clear_model(); model_run(0, 16, 0); model_run(0, 16, 20);
      run_capture(0, 44, 5, 19, 20, -1);
      checks++;
      if (w_ev.size() != ew_ev.size()) $display("FAIL busy_nwrites got %0d want %0d", w_ev.size(), ew_ev.size());
      else passes++;
      for (int i = 0; i < w_ev.size() && i < ew_ev.size(); i++) begin
         checks++;
         if (w_ev[i] !== ew_ev[i] || w_dat[i] !== ew_dat[i])
            $display("FAIL busy_write%0d got cyc %0d addr %0d data %h want cyc %0d addr %0d data %h",
                     i, w_ev[i] / 16, w_ev[i] % 16, w_dat[i], ew_ev[i] / 16, ew_ev[i] % 16, ew_dat[i]);
         else passes++;
      end
      checks++;
      if (d_ev.size() != 2 || d_ev[0] != 19 || d_ev[1] != 39)
         $display("FAIL busy_done got %0d pulses first %0d want 2 at 19 and 39", d_ev.size(), (d_ev.size() > 0) ? d_ev[0] : -1);
      else passes++;
      checks++;
      if (r_ev.size() != 32) $display("FAIL busy_nreads got %0d want 32", r_ev.size());
      else passes++;
   endtask

   task automatic test_reset_mid();
      int nrd;
      // Start and reset in the same cycle: nothing may happen.
      run_capture(0, 10, -1, -1, -1, 0);
      checks++;
      if (w_ev.size() != 0 || r_ev.size() != 0 || d_ev.size() != 0)
         $display("FAIL start_rst_same got %0d writes %0d reads %0d done want 0 0 0", w_ev.size(), r_ev.size(), d_ev.size());
      else passes++;
      // Reset in cycle 8: only activity up to cycle 8 survives.
      for (int k = 0; k < SD; k++) src_mem[0][k] = NW'($urandom);
      clear_model(); model_run(0, 16, 0);
      run_capture(0, 24, -1, -1, -1, 8);
      checks++;
      if (w_ev.size() != 1 || w_ev[0] !== ew_ev[0] || w_dat[0] !== ew_dat[0])
         $display("FAIL rstmid_writes got %0d writes first %h want 1 write %h at cyc %0d",
                  w_ev.size(), (w_dat.size() > 0) ? w_dat[0] : 32'h0, ew_dat[0], ew_ev[0] / 16);
      else passes++;
      nrd = 0;
      foreach (er_ev[i]) if (er_ev[i] / 256 <= 8) nrd++;
      checks++;
      if (r_ev.size() != nrd) $display("FAIL rstmid_reads got %0d want %0d", r_ev.size(), nrd);
      else passes++;
      checks++;
      if (d_ev.size() != 0 || idle_bad != 0) $display("FAIL rstmid_quiet got %0d done %0d idle errs want 0 0", d_ev.size(), idle_bad);
      else passes++;
      // A clean run follows.
      run_capture(0, 24, -1, -1, -1, -1);
      checks++;
      if (w_ev.size() != ew_ev.size()) $display("FAIL rstmid_rerun_n got %0d want %0d", w_ev.size(), ew_ev.size());
      else passes++;
      for (int i = 0; i < w_ev.size() && i < ew_ev.size(); i++) begin
         checks++;
         if (w_ev[i] !== ew_ev[i] || w_dat[i] !== ew_dat[i])
            $display("FAIL rstmid_rerun%0d got cyc %0d data %h want cyc %0d data %h",
                     i, w_ev[i] / 16, w_dat[i], ew_ev[i] / 16, ew_dat[i]);
         else passes++;
      end
      checks++;
      if (d_ev.size() != 1 || d_ev[0] != 19) $display("FAIL rstmid_rerun_done got %0d pulses want 1 at 19", d_ev.size());
      else passes++;
   endtask

   // Round trip through a parser model: the unpacked destination must equal the source byte for byte.
   task automatic test_round_trip();
      logic [WW-1:0] dest [DD];
      logic [NW-1:0] got;
      int g, nn, nw, a, bad;
      for (int it = 0; it < 6; it++) begin
         g  = it % 3;
         nn = nn_of(g);
         nw = (nn + R - 1) / R;
         for (int k = 0; k < SD; k++) src_mem[g][k] = NW'($urandom);
         for (int d = 0; d < DD; d++) dest[d] = '1;
         run_capture(g, nn + 6, -1, -1, -1, -1);
         checks++;
         if (w_ev.size() != nw) $display("FAIL rt%0d_nwrites got %0d want %0d", it, w_ev.size(), nw);
         else passes++;
         foreach (w_ev[i]) begin
            a = w_ev[i] % 16;
            if (a < DD) dest[a] = w_dat[i];
         end
         bad = 0;
         for (int k = 0; k < nw * R; k++) begin
            got = NW'(dest[k / R] >> (WW - NW * (k % R + 1)));
            if (k < nn && got !== src_mem[g][k]) bad++;
            if (k >= nn && got !== '0) bad++;
         end
         checks++;
         if (bad != 0) $display("FAIL rt%0d_bytes got %0d mismatching bytes want 0", it, bad);
         else passes++;
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_partial();
      test_minimal();
      test_start_busy();
      test_reset_mid();
      test_round_trip();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
